// File: rtl/score_display_if.sv
// Bus between the score source and the 3-digit display driver: score load handshake
// plus the multiplexed 7-segment pin drive.
interface score_display_if;
  logic [7:0] points;
  logic       load;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [2:0] digit_sel;

  modport master (
    output points,
    output load,
    input  busy,
    input  done,
    input  seg,
    input  digit_sel
  );

  modport slave (
    input  points,
    input  load,
    output busy,
    output done,
    output seg,
    output digit_sel
  );
endinterface

// File: rtl/score_display.sv
// Serial binary-to-BCD (shift-add-3) score converter driving a 3-digit multiplexed display.
// Optional leading-zero blanking is enabled by defining SCORE_BLANK_ZEROS_EN.
module score_display #(
  parameter int unsigned REFRESH_CYCLES = 1000
) (
  input  logic           i_clock,
  input  logic           i_reset,
  score_display_if.slave io_disp
);

  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);
  localparam logic [CntW-1:0] RefLast = CntW'(REFRESH_CYCLES - 1);

  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [6:0] SegBlank = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ScanUnits,
    ScanTens,
    ScanHund
  } scan_e;

  state_e          r_state;
  logic [19:0]     r_work;
  logic [2:0]      r_bits;
  logic [3:0]      r_hund;
  logic [3:0]      r_tens;
  logic [3:0]      r_units;
  logic            r_busy;
  logic            r_done;
  logic [CntW-1:0] r_ref;
  scan_e           r_scan;
  logic [6:0]      r_seg;
  logic [2:0]      r_digit_sel;

  logic [19:0] w_adj;
  logic [19:0] w_shift;
  logic        w_last;
  logic        w_wrap;
  logic [3:0]  w_hund_n;
  logic [3:0]  w_tens_n;
  logic [3:0]  w_units_n;
  scan_e       w_scan_n;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_seg_n;
  logic [2:0]  w_sel_n;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Double-dabble step: correct each BCD nibble, then shift {bcd,bin} left.
  always_comb begin
    w_adj = r_work;
    for (int n = 0; n < 3; n++) begin
      if (r_work[8+4*n +: 4] >= 4'd5) begin
        w_adj[8+4*n +: 4] = r_work[8+4*n +: 4] + 4'd3;
      end
    end
    w_shift = {w_adj[18:0], 1'b0};
  end

  // Digits and segment data are computed from next-state values so SEG always
  // matches DIGIT_SEL and new results appear on the same edge as DONE.
  always_comb begin
    w_last    = (r_state == StShift) && (r_bits == 3'd7);
    w_hund_n  = w_last ? w_shift[19:16] : r_hund;
    w_tens_n  = w_last ? w_shift[15:12] : r_tens;
    w_units_n = w_last ? w_shift[11:8]  : r_units;

    w_wrap   = (r_ref == RefLast);
    w_scan_n = r_scan;
    if (w_wrap) begin
      case (r_scan)
        ScanUnits: w_scan_n = ScanTens;
        ScanTens:  w_scan_n = ScanHund;
        default:   w_scan_n = ScanUnits;
      endcase
    end

    case (w_scan_n)
      ScanHund: begin
        w_digit = w_hund_n;
        w_sel_n = 3'b011;
      end
      ScanTens: begin
        w_digit = w_tens_n;
        w_sel_n = 3'b101;
      end
      default: begin
        w_digit = w_units_n;
        w_sel_n = 3'b110;
      end
    endcase

`ifdef SCORE_BLANK_ZEROS_EN
    w_blank = ((w_scan_n == ScanHund) && (w_hund_n == 4'd0)) ||
              ((w_scan_n == ScanTens) && (w_hund_n == 4'd0) && (w_tens_n == 4'd0));
`else
    w_blank = 1'b0;
`endif

    w_seg_n = w_blank ? SegBlank : dec7(w_digit);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_work      <= '0;
      r_bits      <= '0;
      r_hund      <= '0;
      r_tens      <= '0;
      r_units     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ref       <= '0;
      r_scan      <= ScanUnits;
      r_seg       <= SegZero;
      r_digit_sel <= 3'b110;
    end else begin
      r_ref       <= w_wrap ? '0 : r_ref + 1'b1;
      r_scan      <= w_scan_n;
      r_seg       <= w_seg_n;
      r_digit_sel <= w_sel_n;
      r_hund      <= w_hund_n;
      r_tens      <= w_tens_n;
      r_units     <= w_units_n;
      r_done      <= 1'b0;

      case (r_state)
        StIdle: begin
          if (io_disp.load) begin
            r_work  <= {12'd0, io_disp.points};
            r_bits  <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_work <= w_shift;
          r_bits <= r_bits + 1'b1;
          if (r_bits == 3'd7) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_disp.busy      = r_busy;
  assign io_disp.done      = r_done;
  assign io_disp.seg       = r_seg;
  assign io_disp.digit_sel = r_digit_sel;

endmodule
